// File: rtl/dlk_access_checker_if.sv
// dlk_access_checker_if
// Request channel from the LSU into the access checker.
//   req_valid  LSU -> checker  access valid
//   req_ready  checker -> LSU  access accepted when valid & ready
//   req_addr   LSU -> checker  effective address of the access
//   req_base   LSU -> checker  base pointer the access derives from
//   req_store  LSU -> checker  1 = store, 0 = load
// master: LSU side, slave: checker side.
interface dlk_access_checker_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_base;
    logic        req_store;

    modport master (
        output req_valid,
        output req_addr,
        output req_base,
        output req_store,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_base,
        input  req_store,
        output req_ready
    );
endinterface

// File: rtl/dlk_access_checker.sv
// dlk_access_checker
// Queues LSU accesses, presents them one per cycle on the base-address
// buffer's lookup port, and raises a held alert for the first access that
// the buffer flags as overflowing. Keeps a saturating violation count.
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   clear_i            debug flush, same effect as rst_i
//   enable_i           checking enabled; when low, accesses are dropped
//                      and queued entries drain unchecked
//   req                request channel (slave side)
//   chk_valid_o        lookup port owned this cycle
//   chk_base_o/addr_o  lookup base / address (head of queue)
//   overflow_i         buffer overflow flag, same-cycle response to lookup
//   alert_valid_o/ready_i, alert_addr_o/base_o/store_o  offending access
//   viol_count_o       saturating violation count
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CHECK | pop one queued access per cycle (looked up when enabled)
// ST_ALERT | alert held until acknowledged; queue fills, no lookups
module dlk_access_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    dlk_access_checker_if.slave  req,
    output logic                 chk_valid_o,
    output logic [31:0]          chk_base_o,
    output logic [31:0]          chk_addr_o,
    input  logic                 overflow_i,
    output logic                 alert_valid_o,
    input  logic                 alert_ready_i,
    output logic [31:0]          alert_addr_o,
    output logic [31:0]          alert_base_o,
    output logic                 alert_store_o,
    output logic [CNT_W-1:0]     viol_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_ALERT = 1'b1
    } state_t;

    state_t            state_q;
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    wr_ptr_d, rd_ptr_d;
    logic              ready_q;
    logic              alert_valid_q;
    logic [31:0]       alert_addr_q, alert_base_q;
    logic              alert_store_q;
    logic [CNT_W-1:0]  viol_cnt_q;

    logic [31:0]       addr_mem  [FIFO_DEPTH];
    logic [31:0]       base_mem  [FIFO_DEPTH];
    logic              store_mem [FIFO_DEPTH];

    logic              empty, full_d, push, pop, violation;
    logic [PTR_W-1:0]  rd_idx, wr_idx;

    assign rd_idx = rd_ptr_q[PTR_W-1:0];
    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // Disabled checking always accepts (and drops); otherwise readiness is
    // the registered not-full flag, so a full queue never takes a push even
    // if the head pops in the same cycle.
    assign req.req_ready = ready_q | ~enable_i;
    assign push          = req.req_valid & req.req_ready & enable_i;

    // Head leaves the queue every CHECK cycle; it is only looked up when enabled.
    assign pop         = (state_q == ST_CHECK) & ~empty;
    assign chk_valid_o = pop & enable_i;
    assign violation   = chk_valid_o & overflow_i;

    assign chk_addr_o = chk_valid_o ? addr_mem[rd_idx] : 32'h0;
    assign chk_base_o = chk_valid_o ? base_mem[rd_idx] : 32'h0;

    assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    assign full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                      (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_idx]  <= req.req_addr;
            base_mem[wr_idx]  <= req.req_base;
            store_mem[wr_idx] <= req.req_store;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q       <= ST_CHECK;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ready_q       <= 1'b1;
            alert_valid_q <= 1'b0;
            alert_addr_q  <= '0;
            alert_base_q  <= '0;
            alert_store_q <= 1'b0;
            viol_cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ~full_d;
            case (state_q)
                ST_CHECK: begin
                    if (violation) begin
                        state_q       <= ST_ALERT;
                        alert_valid_q <= 1'b1;
                        alert_addr_q  <= addr_mem[rd_idx];
                        alert_base_q  <= base_mem[rd_idx];
                        alert_store_q <= store_mem[rd_idx];
                        if (viol_cnt_q != {CNT_W{1'b1}})
                            viol_cnt_q <= viol_cnt_q + CNT_W'(1);
                    end
                end
                ST_ALERT: begin
                    if (alert_ready_i) begin
                        state_q       <= ST_CHECK;
                        alert_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_CHECK;
            endcase
        end
    end

    assign alert_valid_o = alert_valid_q;
    assign alert_addr_o  = alert_addr_q;
    assign alert_base_o  = alert_base_q;
    assign alert_store_o = alert_store_q;
    assign viol_count_o  = viol_cnt_q;
endmodule

// File: tb/tb_dlk_access_checker.sv
// tb_dlk_access_checker
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a queue-based reference model. A second instance with a 2-bit
// counter shares the stimulus to observe counter saturation.
module tb_dlk_access_checker;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst, clr, en, rv, rs, ovf, ar;
    logic [31:0] ra, rb;

    logic        chk_valid, alert_valid, alert_store;
    logic [31:0] chk_base, chk_addr, alert_addr, alert_base;
    logic [15:0] count;

    logic        chk_valid_s, alert_valid_s, alert_store_s;
    logic [31:0] chk_base_s, chk_addr_s, alert_addr_s, alert_base_s;
    logic [1:0]  count_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } acc_t;

    acc_t        mq[$];
    bit          m_alert;
    logic [31:0] m_aa, m_ab;
    logic        m_as;
    int unsigned m_cnt;

    dlk_access_checker_if if0 ();
    dlk_access_checker_if if1 ();

    assign if0.req_valid = rv;
    assign if0.req_addr  = ra;
    assign if0.req_base  = rb;
    assign if0.req_store = rs;
    assign if1.req_valid = rv;
    assign if1.req_addr  = ra;
    assign if1.req_base  = rb;
    assign if1.req_store = rs;

    dlk_access_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
        .req(if0.slave),
        .chk_valid_o(chk_valid), .chk_base_o(chk_base), .chk_addr_o(chk_addr),
        .overflow_i(ovf),
        .alert_valid_o(alert_valid), .alert_ready_i(ar),
        .alert_addr_o(alert_addr), .alert_base_o(alert_base),
        .alert_store_o(alert_store), .viol_count_o(count)
    );

    dlk_access_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
        .req(if1.slave),
        .chk_valid_o(chk_valid_s), .chk_base_o(chk_base_s), .chk_addr_o(chk_addr_s),
        .overflow_i(ovf),
        .alert_valid_o(alert_valid_s), .alert_ready_i(ar),
        .alert_addr_o(alert_addr_s), .alert_base_o(alert_base_s),
        .alert_store_o(alert_store_s), .viol_count_o(count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_alert = 1'b0;
        m_aa    = '0;
        m_ab    = '0;
        m_as    = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock cycle: compare all outputs with the model at the falling
    // edge, advance the model by the rules, then move past the rising edge.
    task automatic step();
        acc_t        h;
        bit          exp_rdy, exp_cv, acc;
        logic [31:0] exp_ca, exp_cb;
        @(negedge clk);
        exp_rdy = !en || (mq.size() < DEPTH);
        exp_cv  = !m_alert && (mq.size() != 0) && en;
        exp_ca  = 32'h0;
        exp_cb  = 32'h0;
        if (exp_cv) begin
            exp_ca = mq[0].a;
            exp_cb = mq[0].b;
        end
        chk("req_ready",   {63'd0, if0.req_ready}, {63'd0, exp_rdy});
        chk("chk_valid",   {63'd0, chk_valid},     {63'd0, exp_cv});
        chk("chk_addr",    {32'd0, chk_addr},      {32'd0, exp_ca});
        chk("chk_base",    {32'd0, chk_base},      {32'd0, exp_cb});
        chk("alert_valid", {63'd0, alert_valid},   {63'd0, m_alert});
        chk("alert_addr",  {32'd0, alert_addr},    {32'd0, m_aa});
        chk("alert_base",  {32'd0, alert_base},    {32'd0, m_ab});
        chk("alert_store", {63'd0, alert_store},   {63'd0, m_as});
        chk("viol_count",  {48'd0, count},         64'(m_cnt));
        chk("viol_count_small", {62'd0, count_s},  64'((m_cnt > 3) ? 3 : m_cnt));
        chk("alert_valid_small", {63'd0, alert_valid_s}, {63'd0, m_alert});

        if (rst || clr) begin
            model_clear();
        end else begin
            acc = rv && exp_rdy && en;
            if (!m_alert && mq.size() != 0) begin
                h = mq.pop_front();
                if (en && ovf) begin
                    m_alert = 1'b1;
                    m_aa    = h.a;
                    m_ab    = h.b;
                    m_as    = h.s;
                    if (m_cnt < 32'hFFFF) m_cnt++;
                end
            end else if (m_alert && ar) begin
                m_alert = 1'b0;
            end
            if (acc) mq.push_back('{a: ra, b: rb, s: rs});
        end
        @(posedge clk);
        #1;
    endtask

    // Push one access into an empty, checking queue and flag it at lookup.
    task automatic trig(input logic [31:0] a, input logic [31:0] b, input logic s);
        rv = 1'b1; ra = a; rb = b; rs = s; ovf = 1'b0;
        step();
        rv = 1'b0; ovf = 1'b1;
        step();
        ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b1; rv = 1'b0; rs = 1'b0;
        ovf = 1'b0; ar = 1'b0; ra = '0; rb = '0;
        model_clear();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // reset state
        #1;
        chk("rst_ready", {63'd0, if0.req_ready}, 64'd1);
        chk("rst_alert", {63'd0, alert_valid},   64'd0);
        chk("rst_chk",   {63'd0, chk_valid},     64'd0);
        chk("rst_count", {48'd0, count},         64'd0);
        step();

        // clean access: lookup one cycle after acceptance, no alert
        rv = 1'b1; ra = 32'h1010; rb = 32'h1000; rs = 1'b0;
        step();
        rv = 1'b0;
        #1;
        chk("clean_chk_valid", {63'd0, chk_valid}, 64'd1);
        chk("clean_chk_addr",  {32'd0, chk_addr},  64'h1010);
        step();
        chk("clean_no_alert", {63'd0, alert_valid}, 64'd0);
        chk("clean_count",    {48'd0, count},       64'd0);
        step();

        // store violation: alert two cycles after acceptance
        rv = 1'b1; ra = 32'h2040; rb = 32'h2000; rs = 1'b1;
        step();
        rv = 1'b0; ovf = 1'b1;
        #1;
        chk("viol_chk_valid", {63'd0, chk_valid}, 64'd1);
        step();
        ovf = 1'b0;
        #1;
        chk("viol_alert",       {63'd0, alert_valid}, 64'd1);
        chk("viol_alert_addr",  {32'd0, alert_addr},  64'h2040);
        chk("viol_alert_store", {63'd0, alert_store}, 64'd1);
        chk("viol_count",       {48'd0, count},       64'd1);

        // alert held 5 cycles while 5 pushes arrive; only 4 fit
        for (int k = 0; k < 5; k++) begin
            rv = 1'b1; ra = 32'h3000 + 32'(k * 16); rb = 32'h3000; rs = 1'b0;
            #1;
            chk("hold_ready", {63'd0, if0.req_ready}, (k < 4) ? 64'd1 : 64'd0);
            chk("hold_alert", {63'd0, alert_valid},   64'd1);
            step();
        end
        rv = 1'b0; ar = 1'b1;
        step();
        ar = 1'b0;
        #1;
        chk("ack_alert_low", {63'd0, alert_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_chk_valid", {63'd0, chk_valid}, 64'd1);
            chk("drain_chk_addr",  {32'd0, chk_addr},  64'(32'h3000 + 32'(k * 16)));
            step();
        end

        // disabled: queued entries drain unchecked, new requests dropped
        trig(32'h4000, 32'h4000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rv = 1'b1; ra = 32'h5000 + 32'(k); rb = 32'h5000;
            step();
        end
        rv = 1'b0; en = 1'b0; ar = 1'b1;
        step();
        ar = 1'b0; rv = 1'b1; ra = 32'h6000; ovf = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("dis_chk_valid", {63'd0, chk_valid},     64'd0);
            chk("dis_ready",     {63'd0, if0.req_ready}, 64'd1);
            step();
        end
        rv = 1'b0; ovf = 1'b0; en = 1'b1;
        #1;
        chk("dis_empty",    {63'd0, chk_valid},   64'd0);
        chk("dis_no_alert", {63'd0, alert_valid}, 64'd0);
        chk("dis_count",    {48'd0, count},       64'd2);
        step();

        // clear overrides a pending alert and its same-cycle handshake
        trig(32'h7000, 32'h7000, 1'b1);
        rv = 1'b1; ra = 32'h7100; step();
        rv = 1'b0;
        ar = 1'b1; clr = 1'b1;
        step();
        ar = 1'b0; clr = 1'b0;
        #1;
        chk("clr_alert", {63'd0, alert_valid},   64'd0);
        chk("clr_count", {48'd0, count},         64'd0);
        chk("clr_chk",   {63'd0, chk_valid},     64'd0);
        chk("clr_ready", {63'd0, if0.req_ready}, 64'd1);
        step();

        // counter saturation on the narrow instance
        for (int k = 0; k < 4; k++) begin
            trig(32'h8000 + 32'(k), 32'h8000, 1'b0);
            ar = 1'b1;
            step();
            ar = 1'b0;
        end
        #1;
        chk("sat_count_small", {62'd0, count_s}, 64'd3);
        chk("sat_count_wide",  {48'd0, count},   64'd4);
        step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            en  = ($urandom_range(9) != 0);
            rv  = 1'($urandom_range(1));
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(1));
            ovf = ($urandom_range(2) == 0);
            ar  = 1'($urandom_range(1));
            clr = ($urandom_range(49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
